// File: rtl/multicycle_controlunit.sv
// Multicycle RV32-style control FSM: FETCH/DECODE/EXEC/MEM/WB with a bounded memory handshake.
// Sticky illegal/fault flags park the FSM in HALT until reset; retired counts completed instructions.
module multicycle_controlunit #(
  parameter int TIMEOUT = 16,
  parameter int RET_W   = 32,
  parameter int EN_JUMP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       memto_reg,
  output logic             illegal,
  output logic             mem_fault,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam bit         JUMP_OK   = (EN_JUMP != 0);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             retire;

  logic       mem_req_c, mem_we_c, ir_write_c, pc_write_c, pc_write_cond_c;
  logic       alu_src_b_c, reg_write_c;
  logic [1:0] pc_src_c, alu_op_c, memto_reg_c;

  always_comb begin
    dec_cls = C_ILL;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = JUMP_OK ? C_JAL   : C_ILL;
      7'b1100111: dec_cls = JUMP_OK ? C_JALR  : C_ILL;
      7'b0110111: dec_cls = JUMP_OK ? C_LUI   : C_ILL;
      7'b0010111: dec_cls = JUMP_OK ? C_AUIPC : C_ILL;
      default:    dec_cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cls_d           = cls_q;
    wait_d          = wait_q;
    illegal_d       = illegal_q;
    fault_d         = fault_q;
    retire          = 1'b0;
    mem_req_c       = 1'b0;
    mem_we_c        = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_src_c        = 2'b00;
    alu_src_b_c     = 1'b0;
    alu_op_c        = 2'b00;
    reg_write_c     = 1'b0;
    memto_reg_c     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILL) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (cls_q)
          C_R: alu_op_c = 2'b10;
          C_I: begin
            alu_src_b_c = 1'b1;
            alu_op_c    = 2'b11;
          end
          C_LOAD, C_STORE: begin
            alu_src_b_c = 1'b1;
            state_d     = S_MEM;
            wait_d      = '0;
          end
          C_BRANCH: begin
            alu_op_c        = 2'b01;
            pc_write_cond_c = 1'b1;
            pc_src_c        = 2'b01;
            state_d         = S_FETCH;
            wait_d          = '0;
            retire          = 1'b1;
          end
          C_JAL: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'b10;
          end
          C_JALR: begin
            pc_write_c  = 1'b1;
            pc_src_c    = 2'b11;
            alu_src_b_c = 1'b1;
          end
          C_LUI, C_AUIPC: alu_src_b_c = 1'b1;
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            state_d = S_FETCH;
            wait_d  = '0;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        case (cls_q)
          C_LOAD:         memto_reg_c = 2'b01;
          C_JAL, C_JALR:  memto_reg_c = 2'b10;
          C_LUI:          memto_reg_c = 2'b11;
          default:        memto_reg_c = 2'b00;
        endcase
        state_d = S_FETCH;
        wait_d  = '0;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    retired_d = retire ? retired_q + RET_W'(1) : retired_q;
  end

  // Strobes are gated by rst so they drop the instant reset asserts, not at the next edge.
  assign mem_req       = mem_req_c       & ~rst;
  assign mem_we        = mem_we_c        & ~rst;
  assign ir_write      = ir_write_c      & ~rst;
  assign pc_write      = pc_write_c      & ~rst;
  assign pc_write_cond = pc_write_cond_c & ~rst;
  assign alu_src_b     = alu_src_b_c     & ~rst;
  assign reg_write     = reg_write_c     & ~rst;
  assign pc_src        = rst ? 2'b00 : pc_src_c;
  assign alu_op        = rst ? 2'b00 : alu_op_c;
  assign memto_reg     = rst ? 2'b00 : memto_reg_c;
  assign illegal       = illegal_q;
  assign mem_fault     = fault_q;
  assign retired       = retired_q;

endmodule
